// File: rtl/systolic_array_driver_if.sv
// Host-side interface of systolic_array_driver: element write port,
// start/status handshake and the combinational C read port.
interface systolic_array_driver_if #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 3
);
  localparam int IW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;

  logic                   wr_en;
  logic                   wr_sel;
  logic [IW-1:0]          wr_row;
  logic [IW-1:0]          wr_col;
  logic [DATAWIDTH-1:0]   wr_data;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [IW-1:0]          rd_row;
  logic [IW-1:0]          rd_col;
  logic [2*DATAWIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start, rd_row, rd_col,
    input  busy, done, error, rd_data
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start, rd_row, rd_col,
    output busy, done, error, rd_data
  );
endinterface

// File: rtl/systolic_array_driver.sv
// Initiator-side sequencer for systolic_array_top. Holds A/B operand
// buffers written by the host, clears the array, streams A column-wise and
// B row-wise, then captures the result rows into a C buffer readable by the
// host. Optional macro SYSTOLIC_TIMEOUT_EN adds a COLLECT watchdog that
// ends the run with error set when the array stops producing rows.
//
// state   | meaning
// IDLE    | accept writes/start, array released
// CLEAR   | array held in reset, C buffer and counters zeroed
// FEED    | one operand column/row per cycle, valid_in high
// COLLECT | capture one result row per valid_out cycle
// DONE    | C complete and retained, behaves like IDLE
module systolic_array_driver #(
  parameter int DATAWIDTH      = 16,
  parameter int N_SIZE         = 3,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  systolic_array_driver_if.slave host,
  output logic                   arr_rst_n,
  output logic                   valid_in,
  output logic [DATAWIDTH-1:0]   matrix_a_in  [N_SIZE-1:0],
  output logic [DATAWIDTH-1:0]   matrix_b_in  [N_SIZE-1:0],
  input  logic [2*DATAWIDTH-1:0] matrix_c_out [N_SIZE-1:0],
  input  logic                   valid_out
);
  localparam int IW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
  // clr_cnt counts CLR_CYCLES-1 down to 0
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [IW:0] N_LIM = (IW+1)'(N_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [CW-1:0]          clr_cnt;
  logic [IW-1:0]          k_cnt;
  logic [IW-1:0]          k_nxt;
  logic [IW-1:0]          row_cnt;
  logic                   busy_q;
  logic                   done_q;
  logic                   wr_ok;
  logic                   rd_ok;

  logic [DATAWIDTH-1:0]   a_buf [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0]   b_buf [N_SIZE][N_SIZE];
  logic [2*DATAWIDTH-1:0] c_buf [N_SIZE][N_SIZE];

`ifdef SYSTOLIC_TIMEOUT_EN
  logic [15:0]            wdog;
  logic                   error_q;
  assign host.error = error_q;
`else
  logic                   unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
  assign host.error = 1'b0;
`endif

  assign k_nxt = k_cnt + 1'b1;
  assign wr_ok = ({1'b0, host.wr_row} < N_LIM) && ({1'b0, host.wr_col} < N_LIM);
  assign rd_ok = ({1'b0, host.rd_row} < N_LIM) && ({1'b0, host.rd_col} < N_LIM);

  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.rd_data = rd_ok ? c_buf[host.rd_row][host.rd_col] : '0;

  // Sequencer: operand buffers, array drive, result capture and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      k_cnt     <= '0;
      row_cnt   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arr_rst_n <= 1'b0;
      valid_in  <= 1'b0;
`ifdef SYSTOLIC_TIMEOUT_EN
      wdog      <= '0;
      error_q   <= 1'b0;
`endif
      for (int i = 0; i < N_SIZE; i++) begin
        matrix_a_in[i] <= '0;
        matrix_b_in[i] <= '0;
        for (int j = 0; j < N_SIZE; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
          c_buf[i][j] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          arr_rst_n <= 1'b1;
          // the write lands on the same edge as start, so it is fed
          if (host.wr_en && wr_ok) begin
            if (host.wr_sel) b_buf[host.wr_row][host.wr_col] <= host.wr_data;
            else             a_buf[host.wr_row][host.wr_col] <= host.wr_data;
          end
          if (host.start) begin
            state     <= S_CLEAR;
            busy_q    <= 1'b1;
            arr_rst_n <= 1'b0;
            clr_cnt   <= CW'(CLR_CYCLES - 1);
`ifdef SYSTOLIC_TIMEOUT_EN
            error_q   <= 1'b0;
`endif
          end
        end

        S_CLEAR: begin
          row_cnt <= '0;
`ifdef SYSTOLIC_TIMEOUT_EN
          wdog    <= '0;
`endif
          for (int i = 0; i < N_SIZE; i++)
            for (int j = 0; j < N_SIZE; j++)
              c_buf[i][j] <= '0;
          if (clr_cnt == '0) begin
            state     <= S_FEED;
            arr_rst_n <= 1'b1;
            valid_in  <= 1'b1;
            k_cnt     <= '0;
            for (int i = 0; i < N_SIZE; i++) begin
              matrix_a_in[i] <= a_buf[i][0];
              matrix_b_in[i] <= b_buf[0][i];
            end
          end else begin
            clr_cnt <= clr_cnt - 1'b1;
          end
        end

        S_FEED: begin
          if (k_cnt == IW'(N_SIZE - 1)) begin
            state    <= S_COLLECT;
            valid_in <= 1'b0;
            for (int i = 0; i < N_SIZE; i++) begin
              matrix_a_in[i] <= '0;
              matrix_b_in[i] <= '0;
            end
          end else begin
            k_cnt <= k_nxt;
            for (int i = 0; i < N_SIZE; i++) begin
              matrix_a_in[i] <= a_buf[i][k_nxt];
              matrix_b_in[i] <= b_buf[k_nxt][i];
            end
          end
        end

        S_COLLECT: begin
          if (valid_out) begin
            for (int j = 0; j < N_SIZE; j++)
              c_buf[row_cnt][j] <= matrix_c_out[j];
`ifdef SYSTOLIC_TIMEOUT_EN
            wdog <= '0;
`endif
            if (row_cnt == IW'(N_SIZE - 1)) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
`ifdef SYSTOLIC_TIMEOUT_EN
          else if (wdog == 16'(TIMEOUT_CYCLES - 1)) begin
            state   <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else begin
            wdog <= wdog + 16'd1;
          end
`endif
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_array_driver.sv
// Directed bench for systolic_array_driver with a behavioural array model
// that accumulates the fed operands and returns result rows with a
// configurable gap (or never, to exercise the optional watchdog).
module tb_systolic_array_driver;
  localparam int DW = 16;
  localparam int N  = 3;

  localparam logic [0:8][15:0] M1  = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
  localparam logic [0:8][31:0] C1  = {32'd30, 32'd36, 32'd42, 32'd66, 32'd81, 32'd96, 32'd102, 32'd126, 32'd150};
  localparam logic [0:8][15:0] A2  = {16'd2, 16'd1, 16'd3, 16'd0, 16'd4, 16'd2, 16'd1, 16'd3, 16'd5};
  localparam logic [0:8][15:0] A2X = {16'd2, 16'd1, 16'd3, 16'd0, 16'd4, 16'd2, 16'd1, 16'd3, 16'd0};
  localparam logic [0:8][15:0] B2  = {16'd1, 16'd0, 16'd2, 16'd3, 16'd1, 16'd4, 16'd2, 16'd2, 16'd1};
  localparam logic [0:8][31:0] C2  = {32'd11, 32'd7, 32'd11, 32'd16, 32'd8, 32'd18, 32'd20, 32'd13, 32'd19};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arr_rst_n, valid_in, valid_out;
  logic [DW-1:0]   matrix_a_in  [N-1:0];
  logic [DW-1:0]   matrix_b_in  [N-1:0];
  logic [2*DW-1:0] matrix_c_out [N-1:0];

  int n_vec = 0;
  int n_err = 0;

  // array model controls and state
  bit  silent = 1'b0;
  int  gap_cfg = 0;
  int  model_rows = 0;
  logic [31:0] acc [N][N];
  bit  prev_vin = 1'b0;
  bit  emitting = 1'b0;
  int  erow = 0;
  int  gcnt = 0;

  logic [47:0] fa [N];
  logic [47:0] fb [N];
  int nfeed;

  systolic_array_driver_if #(.DATAWIDTH(DW), .N_SIZE(N)) h ();

  systolic_array_driver #(
    .DATAWIDTH(DW), .N_SIZE(N), .CLR_CYCLES(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (h),
    .arr_rst_n    (arr_rst_n),
    .valid_in     (valid_in),
    .matrix_a_in  (matrix_a_in),
    .matrix_b_in  (matrix_b_in),
    .matrix_c_out (matrix_c_out),
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  // behavioural array: outer-product accumulate while fed, then emit rows
  always @(negedge clk) begin
    if (!arr_rst_n) begin
      for (int i = 0; i < N; i++) begin
        matrix_c_out[i] = '0;
        for (int j = 0; j < N; j++) acc[i][j] = '0;
      end
      prev_vin = 1'b0; emitting = 1'b0; erow = 0; gcnt = 0;
      valid_out = 1'b0; model_rows = 0;
    end else begin
      valid_out = 1'b0;
      if (valid_in)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] = acc[i][j] + 32'(matrix_a_in[i]) * 32'(matrix_b_in[j]);
      if (prev_vin && !valid_in && !silent) begin
        emitting = 1'b1; erow = 0; gcnt = 0;
      end
      prev_vin = valid_in;
      if (emitting) begin
        if (gcnt > 0) gcnt--;
        else begin
          valid_out = 1'b1;
          for (int j = 0; j < N; j++) matrix_c_out[j] = acc[erow][j];
          erow++; model_rows++; gcnt = gap_cfg;
          if (erow == N) emitting = 1'b0;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_elem(input bit sel, input int r, input int c, input logic [15:0] d);
    @(negedge clk);
    h.wr_sel = sel; h.wr_row = 2'(r); h.wr_col = 2'(c); h.wr_data = d; h.wr_en = 1'b1;
    @(negedge clk);
    h.wr_en = 1'b0;
  endtask

  task automatic load(input logic [0:8][15:0] ma, input logic [0:8][15:0] mb);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_elem(1'b0, r, c, ma[r*3+c]);
        write_elem(1'b1, r, c, mb[r*3+c]);
      end
  endtask

  // caller has already raised start at a negedge
  task automatic watch(input int limit, input bit inject, output int clr, output int ndone,
                       output int done_it, output bit err_at_done, output bit early,
                       output logic [31:0] c00_2);
    clr = 0; ndone = 0; done_it = 0; err_at_done = 1'b0; early = 1'b0; c00_2 = '0; nfeed = 0;
    h.rd_row = '0; h.rd_col = '0;
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      h.start = 1'b0; h.wr_en = 1'b0;
      if (t == 2) c00_2 = h.rd_data;
      if (!arr_rst_n) clr++;
      if (valid_in) begin
        if (nfeed < N) begin
          fa[nfeed] = {matrix_a_in[0], matrix_a_in[1], matrix_a_in[2]};
          fb[nfeed] = {matrix_b_in[0], matrix_b_in[1], matrix_b_in[2]};
        end
        nfeed++;
        if (inject && nfeed == 2) begin
          h.start = 1'b1; h.wr_en = 1'b1; h.wr_sel = 1'b0;
          h.wr_row = '0; h.wr_col = '0; h.wr_data = 16'd99;
        end
      end
      if (h.done) begin
        ndone++;
        if (done_it == 0) begin
          done_it = t; err_at_done = h.error;
          if (!silent && model_rows < N) early = 1'b1;
        end
      end
      if (done_it != 0 && t >= done_it + 3) break;
    end
  endtask

  task automatic check_feed(input string tag, input logic [0:8][15:0] ma, input logic [0:8][15:0] mb);
    logic [47:0] ea, eb;
    check_val({tag, "_nfeed"}, 64'(nfeed), 64'(N));
    for (int k = 0; k < N; k++) begin
      ea = {ma[k], ma[3+k], ma[6+k]};
      eb = {mb[3*k], mb[3*k+1], mb[3*k+2]};
      check_val($sformatf("%s_a%0d", tag, k), 64'(fa[k]), 64'(ea));
      check_val($sformatf("%s_b%0d", tag, k), 64'(fb[k]), 64'(eb));
    end
  endtask

  task automatic check_c(input string tag, input logic [0:8][31:0] exp);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        @(negedge clk);
        h.rd_row = 2'(r); h.rd_col = 2'(c);
        #1;
        check_val($sformatf("%s_c%0d%0d", tag, r, c), 64'(h.rd_data), 64'(exp[r*3+c]));
      end
  endtask

  task automatic check_run(input string tag, input int clr, input int ndone, input bit err,
                           input bit early);
    check_val({tag, "_clr_cycles"}, 64'(clr), 64'd2);
    check_val({tag, "_done_count"}, 64'(ndone), 64'd1);
    check_val({tag, "_error"}, 64'(err), 64'd0);
    check_val({tag, "_early_done"}, 64'(early), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int clr, ndone, done_it, cnt;
    bit err, early;
    logic [31:0] c00;

    h.wr_en = 1'b0; h.wr_sel = 1'b0; h.wr_row = '0; h.wr_col = '0; h.wr_data = '0;
    h.start = 1'b0; h.rd_row = '0; h.rd_col = '0;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", 64'(h.busy), 64'd0);
    check_val("rst_done", 64'(h.done), 64'd0);
    check_val("rst_error", 64'(h.error), 64'd0);
    check_val("rst_valid_in", 64'(valid_in), 64'd0);
    check_val("rst_arr_rst_n", 64'(arr_rst_n), 64'd0);
    check_val("rst_a_in", 64'({matrix_a_in[0], matrix_a_in[1], matrix_a_in[2]}), 64'd0);
    check_val("rst_rd00", 64'(h.rd_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // run 1: A = B = M1
    load(M1, M1);
    h.start = 1'b1;
    watch(100, 1'b0, clr, ndone, done_it, err, early, c00);
    check_run("run1", clr, ndone, err, early);
    check_feed("run1", M1, M1);
    check_c("run1", C1);
    @(negedge clk);
    h.rd_row = 2'd3; h.rd_col = 2'd0;
    #1;
    check_val("rd_out_of_range", 64'(h.rd_data), 64'd0);

    // run 2: start from DONE, final A element written in the start cycle
    load(A2X, B2);
    @(negedge clk);
    h.wr_sel = 1'b0; h.wr_row = 2'd2; h.wr_col = 2'd2; h.wr_data = 16'd5;
    h.wr_en = 1'b1; h.start = 1'b1;
    watch(100, 1'b0, clr, ndone, done_it, err, early, c00);
    check_val("run2_c_cleared", 64'(c00), 64'd0);
    check_run("run2", clr, ndone, err, early);
    check_feed("run2", A2, B2);
    check_c("run2", C2);

    // run 3: start and wr_en pulsed mid-FEED are ignored
    load(M1, M1);
    h.start = 1'b1;
    watch(100, 1'b1, clr, ndone, done_it, err, early, c00);
    check_run("run3", clr, ndone, err, early);
    check_feed("run3", M1, M1);
    check_c("run3", C1);

    // run 4: array leaves 2 idle cycles between rows; A unchanged by run 3 write
    gap_cfg = 2;
    @(negedge clk);
    h.start = 1'b1;
    watch(100, 1'b0, clr, ndone, done_it, err, early, c00);
    check_run("run4", clr, ndone, err, early);
    check_feed("run4", M1, M1);
    check_c("run4", C1);
    gap_cfg = 0;

    // reset after the second fed column
    @(negedge clk);
    h.start = 1'b1;
    cnt = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      h.start = 1'b0;
      if (valid_in) cnt++;
      if (cnt == 2) break;
    end
    check_val("midfeed_reached", 64'(cnt), 64'd2);
    rst_n = 1'b0;
    h.rd_row = '0; h.rd_col = '0;
    #1;
    check_val("midrst_busy", 64'(h.busy), 64'd0);
    check_val("midrst_valid_in", 64'(valid_in), 64'd0);
    check_val("midrst_arr_rst_n", 64'(arr_rst_n), 64'd0);
    check_val("midrst_a_in", 64'({matrix_a_in[0], matrix_a_in[1], matrix_a_in[2]}), 64'd0);
    check_val("midrst_b_in", 64'({matrix_b_in[0], matrix_b_in[1], matrix_b_in[2]}), 64'd0);
    check_val("midrst_rd00", 64'(h.rd_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load(M1, M1);
    h.start = 1'b1;
    watch(100, 1'b0, clr, ndone, done_it, err, early, c00);
    check_run("post_rst", clr, ndone, err, early);
    check_c("post_rst", C1);

`ifdef SYSTOLIC_TIMEOUT_EN
    // array never answers: watchdog ends the run after 64 COLLECT cycles
    silent = 1'b1;
    @(negedge clk);
    h.start = 1'b1;
    watch(120, 1'b0, clr, ndone, done_it, err, early, c00);
    check_val("to_done_cycle", 64'(done_it), 64'd70);
    check_val("to_done_count", 64'(ndone), 64'd1);
    check_val("to_error_at_done", 64'(err), 64'd1);
    check_val("to_error_hold", 64'(h.error), 64'd1);
    silent = 1'b0;
    @(negedge clk);
    h.start = 1'b1;
    @(negedge clk);
    h.start = 1'b0;
    check_val("to_error_cleared", 64'(h.error), 64'd0);
    repeat (20) @(negedge clk);
    h.rd_row = 2'd1; h.rd_col = 2'd1;
    #1;
    check_val("to_rerun_c11", 64'(h.rd_data), 64'd81);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
